// File: rtl/prf_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : prf_wr_sched
// Purpose  : Write-port scheduler for the 64-entry physical register file.
//            Zero-fills the RAM after reset, round-robin arbitrates the
//            writeback requesters onto the single write port, and keeps the
//            64-bit busy scoreboard used by issue.
// Revision : 1.0 - initial release
// ============================================================================
module prf_wr_sched #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*6-1:0]     req_addr,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   alloc_valid,
  input  logic [5:0]             alloc_addr,
  output logic [63:0]            busy_q,
  output logic                   init_done,
  output logic [5:0]             ram_addrw,
  output logic [WIDTH-1:0]       ram_din,
  output logic                   ram_wea
);

  // Requester vectors are padded to the largest supported count so the
  // cyclic search can use a fixed 3-bit index for any N_REQ in 2..8.
  localparam int c_MAX_REQ = 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [5:0]           r_init_cnt;
  logic [2:0]           r_rr;
  logic                 r_wr_v;
  logic [5:0]           r_wr_addr;
  logic [WIDTH-1:0]     r_wr_data;
  logic [63:0]          r_busy;

  logic [c_MAX_REQ-1:0] w_valid_pad;
  logic [5:0]           w_addr_arr [c_MAX_REQ];
  logic [WIDTH-1:0]     w_data_arr [c_MAX_REQ];
  logic [3:0]           w_scan;
  logic                 w_gnt_vld;
  logic [2:0]           w_gnt;
  logic [3:0]           w_gnt_inc;
  logic [2:0]           w_rr_nxt;
  logic                 w_accept;
  logic [c_MAX_REQ-1:0] w_ready_pad;
  logic [63:0]          w_busy_nxt;

  // Unpack the flat request buses; unused slots read as idle.
  generate
    for (genvar gi = 0; gi < c_MAX_REQ; gi++) begin : g_unpack
      if (gi < N_REQ) begin : g_used
        assign w_valid_pad[gi] = req_valid[gi];
        assign w_addr_arr[gi]  = req_addr[6*gi +: 6];
        assign w_data_arr[gi]  = req_data[WIDTH*gi +: WIDTH];
      end else begin : g_unused
        assign w_valid_pad[gi] = 1'b0;
        assign w_addr_arr[gi]  = 6'd0;
        assign w_data_arr[gi]  = '0;
      end
    end
  endgenerate

  // Cyclic priority search starting at r_rr; scanning from the far end
  // lets the nearest valid requester overwrite earlier candidates.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 3'd0;
    w_scan    = 4'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_rr} + 4'(k);
      if (w_scan >= 4'(N_REQ)) begin
        w_scan = w_scan - 4'(N_REQ);
      end
      if (w_valid_pad[w_scan[2:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_scan[2:0];
      end
    end
  end

  // Pointer advance and one-hot ready; nothing is accepted during the fill.
  assign w_gnt_inc   = {1'b0, w_gnt} + 4'd1;
  assign w_rr_nxt    = (w_gnt_inc == 4'(N_REQ)) ? 3'd0 : w_gnt_inc[2:0];
  assign w_accept    = (r_state == ST_RUN) && w_gnt_vld;
  assign w_ready_pad = w_accept ? (c_MAX_REQ'(1) << w_gnt) : '0;
  assign req_ready   = w_ready_pad[N_REQ-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and RAM write-port drive; INIT writes zero at the fill counter,
  // RUN forwards the staged write, suppressing the hardwired-zero entry 0.
  always_comb begin
    w_state_nxt = r_state;
    init_done   = 1'b0;
    ram_wea     = 1'b0;
    ram_addrw   = 6'd0;
    ram_din     = '0;
    case (r_state)
      ST_INIT: begin
        ram_wea   = 1'b1;
        ram_addrw = r_init_cnt;
        if (r_init_cnt == 6'd63) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        init_done = 1'b1;
        ram_addrw = r_wr_addr;
        ram_din   = r_wr_data;
        ram_wea   = r_wr_v && (r_wr_addr != 6'd0);
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Fill counter, round-robin pointer and the one-deep write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cnt <= 6'd0;
      r_rr       <= 3'd0;
      r_wr_v     <= 1'b0;
      r_wr_addr  <= 6'd0;
      r_wr_data  <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 6'd1;
      end
      r_wr_v <= w_accept;
      if (w_accept) begin
        r_rr      <= w_rr_nxt;
        r_wr_addr <= w_addr_arr[w_gnt];
        r_wr_data <= w_data_arr[w_gnt];
      end
    end
  end

  // Scoreboard update: commit clears, allocation sets and wins a collision,
  // entry 0 is never busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if ((r_state == ST_RUN) && r_wr_v) begin
      w_busy_nxt[r_wr_addr] = 1'b0;
    end
    if (alloc_valid) begin
      w_busy_nxt[alloc_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 64'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_q = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_prf_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_prf_wr_sched
// Purpose  : Self-checking bench for prf_wr_sched: expected RAM writes are
//            queued when a grant is predicted and popped when the write port
//            should carry them; a reference busy map and round-robin pointer
//            run alongside.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prf_wr_sched;

  localparam int WIDTH = 32;
  localparam int N_REQ = 4;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*6-1:0]     req_addr;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   alloc_valid;
  logic [5:0]             alloc_addr;
  logic [63:0]            busy_q;
  logic                   init_done;
  logic [5:0]             ram_addrw;
  logic [WIDTH-1:0]       ram_din;
  logic                   ram_wea;

  logic [5:0]  adr [N_REQ];
  logic [31:0] dat [N_REQ];

  int n_chk;
  int n_pass;

  wr_t         wq [$];
  logic        model_run;
  logic [63:0] busy_m;
  logic [2:0]  rr_m;

  logic [3:0]  obs_ready;
  logic        obs_wea;
  logic [5:0]  obs_addrw;
  logic [31:0] obs_din;
  logic [63:0] obs_busy;

  prf_wr_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .alloc_valid(alloc_valid),
    .alloc_addr (alloc_addr),
    .busy_q     (busy_q),
    .init_done  (init_done),
    .ram_addrw  (ram_addrw),
    .ram_din    (ram_din),
    .ram_wea    (ram_wea)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-requester stimulus onto the flat buses.
  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_addr[6*i +: 6]      = adr[i];
      req_data[WIDTH*i +: WIDTH] = dat[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, check against the reference,
  // then advance the reference past the rising edge.
  task automatic cycle();
    logic [63:0] nb;
    logic [2:0]  rr_n;
    logic        gv;
    int          g;
    int          idx;
    wr_t         e;
    @(negedge clk);
    obs_ready = req_ready;
    obs_wea   = ram_wea;
    obs_addrw = ram_addrw;
    obs_din   = ram_din;
    obs_busy  = busy_q;
    nb        = busy_m;
    rr_n      = rr_m;
    if (model_run) begin
      chk("init_done_run", 64'(init_done), 64'd1);
      chk("busy_q", busy_q, busy_m);
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_wea", 64'(ram_wea), 64'(e.a != 6'd0));
        if (e.a != 6'd0) begin
          chk("wr_addr", 64'(ram_addrw), 64'(e.a));
          chk("wr_din", 64'(ram_din), 64'(e.d));
        end
        nb[e.a] = 1'b0;
      end else begin
        chk("wea_idle", 64'(ram_wea), 64'd0);
      end
      if (alloc_valid) nb[alloc_addr] = 1'b1;
      nb[0] = 1'b0;
      gv = 1'b0;
      g  = 0;
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(rr_m) + k) % N_REQ;
        if (!gv && req_valid[idx]) begin
          gv = 1'b1;
          g  = idx;
        end
      end
      chk("req_ready", 64'(req_ready), gv ? (64'd1 << g) : 64'd0);
      if (gv) begin
        wq.push_back('{a: adr[g], d: dat[g]});
        rr_n = 3'((g + 1) % N_REQ);
      end
    end
    @(posedge clk);
    #1;
    if (model_run) begin
      busy_m = nb;
      rr_m   = rr_n;
    end
  endtask

  // Follow the 64-cycle zero-fill after reset release.
  task automatic init_seq();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("init_wea", 64'(ram_wea), 64'd1);
      chk("init_addr", 64'(ram_addrw), 64'(k));
      chk("init_din", 64'(ram_din), 64'd0);
      chk("init_ready", 64'(req_ready), 64'd0);
      chk("init_done_lo", 64'(init_done), 64'd0);
      @(posedge clk);
      #1;
    end
    model_run = 1'b1;
    rr_m      = 3'd0;
    busy_m    = 64'd0;
    wq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_r1 [4];
    logic [3:0] exp_r2 [4];
    logic [5:0] exp_a2 [4];
    n_chk       = 0;
    n_pass      = 0;
    model_run   = 1'b0;
    busy_m      = 64'd0;
    rr_m        = 3'd0;
    rst_n       = 1'b0;
    req_valid   = 4'hF;
    alloc_valid = 1'b0;
    alloc_addr  = 6'd0;
    for (int i = 0; i < N_REQ; i++) begin
      adr[i] = 6'(i + 1);
      dat[i] = 32'hA000_0000 + 32'(i);
    end

    // Reset values.
    repeat (2) begin
      @(negedge clk);
      chk("rst_wea", 64'(ram_wea), 64'd1);
      chk("rst_addr", 64'(ram_addrw), 64'd0);
      chk("rst_din", 64'(ram_din), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_busy", busy_q, 64'd0);
      chk("rst_done", 64'(init_done), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_seq();

    // Round-robin with all four valid, then with requester 1 dropped.
    exp_r1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_ready", 64'(obs_ready), 64'(exp_r1[i]));
      if (i > 0) chk("rr_addrw", 64'(obs_addrw), 64'(i));
    end
    req_valid = 4'b1101;
    exp_r2 = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
    exp_a2 = '{6'd4, 6'd1, 6'd3, 6'd4};
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr2_ready", 64'(obs_ready), 64'(exp_r2[i]));
      chk("rr2_addrw", 64'(obs_addrw), 64'(exp_a2[i]));
    end
    req_valid = 4'b0000;
    cycle();
    chk("rr_last_addrw", 64'(obs_addrw), 64'd1);

    // Single write to a freshly allocated entry.
    alloc_valid = 1'b1;
    alloc_addr  = 6'd5;
    cycle();
    alloc_valid = 1'b0;
    req_valid   = 4'b0001;
    adr[0]      = 6'd5;
    dat[0]      = 32'hDEAD_BEEF;
    cycle();
    chk("sw_ready", 64'(obs_ready), 64'b0001);
    chk("sw_busy_set", 64'(obs_busy[5]), 64'd1);
    req_valid = 4'b0000;
    cycle();
    chk("sw_wea", 64'(obs_wea), 64'd1);
    chk("sw_addrw", 64'(obs_addrw), 64'd5);
    chk("sw_din", 64'(obs_din), 64'hDEAD_BEEF);
    chk("sw_busy_pre", 64'(obs_busy[5]), 64'd1);
    cycle();
    chk("sw_busy_clr", 64'(obs_busy[5]), 64'd0);

    // Entry 0: accepted but never written; allocation ignored.
    req_valid   = 4'b0100;
    adr[2]      = 6'd0;
    dat[2]      = 32'h0000_1234;
    alloc_valid = 1'b1;
    alloc_addr  = 6'd0;
    cycle();
    chk("e0_ready", 64'(obs_ready), 64'b0100);
    req_valid   = 4'b0000;
    alloc_valid = 1'b0;
    cycle();
    chk("e0_wea", 64'(obs_wea), 64'd0);
    chk("e0_busy", 64'(obs_busy[0]), 64'd0);

    // Set/clear collision on entry 9.
    alloc_valid = 1'b1;
    alloc_addr  = 6'd9;
    cycle();
    alloc_valid = 1'b0;
    req_valid   = 4'b1000;
    adr[3]      = 6'd9;
    dat[3]      = 32'h0909_0909;
    cycle();
    chk("col_ready", 64'(obs_ready), 64'b1000);
    req_valid   = 4'b0000;
    alloc_valid = 1'b1;
    alloc_addr  = 6'd9;
    cycle();
    chk("col_addrw", 64'(obs_addrw), 64'd9);
    alloc_valid = 1'b0;
    cycle();
    chk("col_busy", 64'(obs_busy[9]), 64'd1);

    // Reset with a write staged and the scoreboard non-empty.
    alloc_valid = 1'b1;
    alloc_addr  = 6'd10;
    cycle();
    alloc_valid = 1'b0;
    req_valid   = 4'b0001;
    adr[0]      = 6'd11;
    dat[0]      = 32'hCAFE_F00D;
    cycle();
    chk("mr_busy_pre", obs_busy, 64'h0000_0000_0000_0600);
    rst_n = 1'b0;
    #1;
    model_run = 1'b0;
    wq.delete();
    chk("mr_busy", busy_q, 64'd0);
    chk("mr_ready", 64'(req_ready), 64'd0);
    chk("mr_done", 64'(init_done), 64'd0);
    chk("mr_wea", 64'(ram_wea), 64'd1);
    chk("mr_addr", 64'(ram_addrw), 64'd0);
    chk("mr_din", 64'(ram_din), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mr_hold_addr", 64'(ram_addrw), 64'd0);
      chk("mr_hold_din", 64'(ram_din), 64'd0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    init_seq();
    req_valid = 4'b0000;
    cycle();
    chk("post_busy", obs_busy, 64'd0);
    chk("post_wea", 64'(obs_wea), 64'd0);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
